// File: rtl/dru_lock_ctrl.sv
// Lock controller for the data recovery unit: sweeps the IDELAY tap until the edge-zone histogram is clean.
// Optional loss_cnt output is compiled in when DRU_LOCK_STATS_EN is defined.
module dru_lock_ctrl #(
    parameter int WIN_LEN    = 256,
    parameter int MAX_SPREAD = 4,
    parameter int LOCK_WINS  = 4,
    parameter int SETTLE     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  edge_in,
    input  logic        edge_vld,
    output logic [4:0]  tap_val,
    output logic        tap_ld,
    output logic [1:0]  zone_sel,
    output logic        locked,
    output logic        sweep_wrap
`ifdef DRU_LOCK_STATS_EN
    ,
    output logic [15:0] loss_cnt
`endif
);

    localparam int WW = $clog2(WIN_LEN);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW = (LOCK_WINS > 1) ? $clog2(LOCK_WINS + 1) : 1;

    localparam logic [WW-1:0] WIN_LAST    = WW'(WIN_LEN - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [9:0]    SPREAD_LIM  = 10'(MAX_SPREAD);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SETTLE = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WW-1:0]    win_cnt;
    logic             win_end;
    logic             win_done;
    logic [3:0][7:0]  zone_cnt;
    logic [3:0][7:0]  zone_nxt;
    logic [SW-1:0]    settle_cnt, settle_nxt;
    logic [CW-1:0]    clean_cnt, clean_nxt;
    logic             miss_cnt, miss_nxt;
    logic             tap_inc;
    logic             tap_ld_q;

    logic [1:0]       dom_idx;
    logic [7:0]       dom_val;
    logic [9:0]       zone_sum;
    logic [9:0]       spread;
    logic             is_clean;

    // The final qualified cycle is counted at win_end; the verdict is taken one cycle later on the full histogram.
    assign win_end = edge_vld && (win_cnt == WIN_LAST) && (state != ST_SETTLE);

    always_comb begin
        dom_idx  = 2'd0;
        dom_val  = zone_cnt[0];
        zone_sum = '0;
        for (int k = 0; k < 4; k++) begin
            zone_sum = zone_sum + 10'(zone_cnt[k]);
            // Strict compare keeps the lowest index on ties.
            if (zone_cnt[k] > dom_val) begin
                dom_val = zone_cnt[k];
                dom_idx = 2'(k);
            end
        end
        spread   = zone_sum - 10'(dom_val);
        is_clean = (spread <= SPREAD_LIM);
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            zone_nxt[k] = win_done ? 8'd0 : zone_cnt[k];
            if (edge_vld && edge_in[k] && (zone_nxt[k] != 8'hFF))
                zone_nxt[k] = zone_nxt[k] + 8'd1;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt  = state;
        settle_nxt = '0;
        clean_nxt  = clean_cnt;
        miss_nxt   = miss_cnt;
        tap_inc    = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (win_done) begin
                    if (is_clean) begin
                        clean_nxt = CW'(1);
                        state_nxt = (LOCK_WINS <= 1) ? ST_LOCKED : ST_TRACK;
                    end else begin
                        tap_inc   = 1'b1;
                        state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST)
                    state_nxt = ST_SEARCH;
                else
                    settle_nxt = settle_cnt + SW'(1);
            end
            ST_TRACK: begin
                if (win_done) begin
                    if (is_clean) begin
                        clean_nxt = clean_cnt + CW'(1);
                        if (int'(clean_cnt) + 1 >= LOCK_WINS) begin
                            state_nxt = ST_LOCKED;
                            miss_nxt  = 1'b0;
                        end
                    end else begin
                        clean_nxt = '0;
                        tap_inc   = 1'b1;
                        state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_LOCKED: begin
                if (win_done) begin
                    if (is_clean) begin
                        miss_nxt = 1'b0;
                    end else if (miss_cnt) begin
                        miss_nxt  = 1'b0;
                        clean_nxt = '0;
                        tap_inc   = 1'b1;
                        state_nxt = ST_SETTLE;
                    end else begin
                        miss_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SEARCH;
            win_cnt    <= '0;
            win_done   <= 1'b0;
            zone_cnt   <= '0;
            settle_cnt <= '0;
            clean_cnt  <= '0;
            miss_cnt   <= 1'b0;
            tap_val    <= 5'd0;
            tap_ld_q   <= 1'b1;
            zone_sel   <= 2'd0;
            sweep_wrap <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            clean_cnt  <= clean_nxt;
            miss_cnt   <= miss_nxt;
            win_done   <= win_end;
            tap_ld_q   <= tap_inc;

            if (state == ST_SETTLE) begin
                win_cnt  <= '0;
                zone_cnt <= '0;
            end else begin
                if (edge_vld)
                    win_cnt <= win_cnt + WW'(1);
                zone_cnt <= zone_nxt;
            end

            if (tap_inc) begin
                tap_val <= tap_val + 5'd1;
                if (tap_val == 5'd31)
                    sweep_wrap <= 1'b1;
            end

            if ((state_nxt == ST_LOCKED) && (state != ST_LOCKED))
                sweep_wrap <= 1'b0;

            if (win_done && ((state == ST_TRACK) || (state == ST_LOCKED)))
                zone_sel <= dom_idx;
        end
    end

    // The reset-time tap load is held back until rst is released, so an aborted cycle never strobes.
    assign tap_ld = tap_ld_q & ~rst;
    assign locked = (state == ST_LOCKED);

`ifdef DRU_LOCK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            loss_cnt <= '0;
        else if ((state == ST_LOCKED) && (state_nxt != ST_LOCKED) && (loss_cnt != 16'hFFFF))
            loss_cnt <= loss_cnt + 16'd1;
    end
`endif

endmodule
